// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding and latency defaults for the HI/LO sequencer
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    MULT_RUN = 2'd2,
    EXC      = 2'd3
  } state_t;

  localparam int DEF_DIV_LATENCY  = 33;
  localparam int DEF_MULT_LATENCY = 33;
  localparam int DEF_CNT_W        = 6;

endpackage

// File: rtl/hilo_unit_op_latency_counter.sv
// rtl/hilo_unit_op_latency_counter.sv - loadable down-counter with zero flag, saturating at 0
module op_latency_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - sequences divider/multiplier ops and owns architectural HI/LO
// HILO_FWD_EN: forward the captured unit result onto hi_out/lo_out during the capture cycle.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int DIV_LATENCY  = DEF_DIV_LATENCY,
  parameter int MULT_LATENCY = DEF_MULT_LATENCY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        div_req,
  input  logic        mult_req,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wr_data,
  output logic        div_start,
  input  logic        div_divzero,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mult_start,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LATENCY);

  state_t           state;
  state_t           next_state;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             capture_div;
  logic             capture_mult;
  logic             enter_exc;

  op_latency_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    div_start    = 1'b0;
    mult_start   = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    capture_div  = 1'b0;
    capture_mult = 1'b0;
    enter_exc    = 1'b0;
    case (state)
      IDLE: begin
        // Divide wins a tie; a held mult_req is picked up on a later IDLE cycle.
        div_start  = div_req;
        mult_start = mult_req & ~div_req;
        if (div_req) begin
          next_state   = DIV_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = DIV_LOAD;
        end else if (mult_req) begin
          next_state   = MULT_RUN;
          cnt_load     = 1'b1;
          cnt_load_val = MULT_LOAD;
        end
      end
      DIV_RUN: begin
        if ((cnt == DIV_LOAD) && div_divzero) begin
          next_state = EXC;
          enter_exc  = 1'b1;
        end else if (cnt_zero) begin
          capture_div = 1'b1;
          next_state  = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MULT_RUN: begin
        if (cnt_zero) begin
          capture_mult = 1'b1;
          next_state   = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      EXC: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Unit results take precedence; mthi/mtlo only land while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (capture_div) begin
      hi_reg <= div_hi;
      lo_reg <= div_lo;
    end else if (capture_mult) begin
      hi_reg <= mult_hi;
      lo_reg <= mult_lo;
    end else if (state == IDLE) begin
      if (mthi_we) begin
        hi_reg <= wr_data;
      end
      if (mtlo_we) begin
        lo_reg <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      done         <= capture_div | capture_mult;
      div_zero_exc <= enter_exc;
    end
  end

  assign busy = (state == DIV_RUN) || (state == MULT_RUN);

`ifdef HILO_FWD_EN
  always_comb begin
    hi_out = hi_reg;
    lo_out = lo_reg;
    if (capture_div) begin
      hi_out = div_hi;
      lo_out = div_lo;
    end else if (capture_mult) begin
      hi_out = mult_hi;
      lo_out = mult_lo;
    end
  end
`else
  assign hi_out = hi_reg;
  assign lo_out = lo_reg;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - directed vector bench for hilo_unit
module tb_hilo_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        div_req, mult_req, mthi_we, mtlo_we;
  logic [31:0] wr_data;
  logic        div_start, div_divzero;
  logic [31:0] div_hi, div_lo;
  logic        mult_start;
  logic [31:0] mult_hi, mult_lo;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero_exc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hilo_unit dut (
    .clk          (clk),
    .reset        (reset),
    .div_req      (div_req),
    .mult_req     (mult_req),
    .mthi_we      (mthi_we),
    .mtlo_we      (mtlo_we),
    .wr_data      (wr_data),
    .div_start    (div_start),
    .div_divzero  (div_divzero),
    .div_hi       (div_hi),
    .div_lo       (div_lo),
    .mult_start   (mult_start),
    .mult_hi      (mult_hi),
    .mult_lo      (mult_lo),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc)
  );

  typedef struct {
    string       name;
    logic        is_div;
    logic        divzero;
    logic [31:0] uhi, ulo;
    logic [31:0] pre_hi, pre_lo;
    logic [31:0] exp_hi, exp_lo;
    int          exp_busy;
    int          exp_done_idx;
    int          exp_exc_idx;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    mthi_we = 1'b1; wr_data = h;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b1; wr_data = l;
    tick();
    mtlo_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int busy_cnt, done_idx, done_cnt, exc_idx, exc_cnt;
    write_hilo(v.pre_hi, v.pre_lo);
    div_divzero = v.divzero;
    if (v.is_div) begin div_hi = v.uhi; div_lo = v.ulo; div_req = 1'b1; end
    else begin mult_hi = v.uhi; mult_lo = v.ulo; mult_req = 1'b1; end
    #1;
    check({v.name, " div_start"}, {31'd0, div_start}, {31'd0, v.is_div});
    check({v.name, " mult_start"}, {31'd0, mult_start}, {31'd0, ~v.is_div});
    tick();
    div_req = 1'b0; mult_req = 1'b0;
    busy_cnt = 0; done_idx = -1; done_cnt = 0; exc_idx = -1; exc_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; if (done_idx < 0) done_idx = k; end
      if (div_zero_exc) begin exc_cnt++; if (exc_idx < 0) exc_idx = k; end
      if (k == 33 && !v.divzero) begin
`ifdef HILO_FWD_EN
        check({v.name, " fwd hi"}, hi_out, v.exp_hi);
        check({v.name, " fwd lo"}, lo_out, v.exp_lo);
`else
        check({v.name, " nofwd hi"}, hi_out, v.pre_hi);
        check({v.name, " nofwd lo"}, lo_out, v.pre_lo);
`endif
      end
    end
    check({v.name, " busy cycles"}, busy_cnt, v.exp_busy);
    check({v.name, " done idx"}, done_idx, v.exp_done_idx);
    check({v.name, " done count"}, done_cnt, (v.exp_done_idx < 0) ? 0 : 1);
    check({v.name, " exc idx"}, exc_idx, v.exp_exc_idx);
    check({v.name, " exc count"}, exc_cnt, (v.exp_exc_idx < 0) ? 0 : 1);
    check({v.name, " hi"}, hi_out, v.exp_hi);
    check({v.name, " lo"}, lo_out, v.exp_lo);
    div_divzero = 1'b0;
  endtask

  initial begin
    int waited;
    int saw_done;
    vecs[0] = '{"div 100/7", 1'b1, 1'b0, 32'd2, 32'd14, 32'h55, 32'h66,
                32'd2, 32'd14, 34, 34, -1};
    vecs[1] = '{"div -7/2", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h55, 32'h66,
                32'hFFFFFFFF, 32'hFFFFFFFD, 34, 34, -1};
    vecs[2] = '{"div 5/0", 1'b1, 1'b1, 32'hDEAD, 32'hBEEF, 32'hAA, 32'hBB,
                32'hAA, 32'hBB, 1, -1, 1};
    vecs[3] = '{"mult 2^16*2^16", 1'b0, 1'b0, 32'd1, 32'd0, 32'h55, 32'h66,
                32'd1, 32'd0, 34, 34, -1};
    vecs[4] = '{"mult -3*5", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h12, 32'h34,
                32'hFFFFFFFF, 32'hFFFFFFF1, 34, 34, -1};

    reset = 1'b1; div_req = 0; mult_req = 0; mthi_we = 0; mtlo_we = 0; wr_data = 0;
    div_divzero = 0; div_hi = 0; div_lo = 0; mult_hi = 0; mult_lo = 0;
    tick(); tick();
    reset = 1'b0;
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    check("reset busy/done/exc", {29'd0, busy, done, div_zero_exc}, 32'd0);
    check("reset starts", {30'd0, div_start, mult_start}, 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Divide and multiply requested together: divide first, multiply on the first IDLE cycle.
    div_hi = 32'd7; div_lo = 32'd9; mult_hi = 32'h100; mult_lo = 32'h200;
    div_req = 1'b1; mult_req = 1'b1;
    #1;
    check("tie div_start", {31'd0, div_start}, 32'd1);
    check("tie mult_start", {31'd0, mult_start}, 32'd0);
    tick();
    div_req = 1'b0;
    tick();
    check("held mult ignored while busy", {30'd0, busy, mult_start}, 32'd2);
    waited = 0;
    while (!done && waited < 60) begin tick(); waited++; end
    check("tie div done seen", {31'd0, done}, 32'd1);
    check("tie div result hi", hi_out, 32'd7);
    check("tie mult_start after div", {30'd0, busy, mult_start}, 32'd1);
    tick();
    mult_req = 1'b0;
    check("tie mult running", {31'd0, busy}, 32'd1);
    waited = 0;
    while (!done && waited < 60) begin tick(); waited++; end
    check("tie mult done seen", {31'd0, done}, 32'd1);
    check("tie mult hi", hi_out, 32'h100);
    check("tie mult lo", lo_out, 32'h200);
    tick();

    // Reset ten edges into a divide; later divider outputs must not land.
    div_hi = 32'h999; div_lo = 32'h888; div_req = 1'b1;
    tick();
    div_req = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset hi", hi_out, 32'd0);
    check("midreset lo", lo_out, 32'd0);
    check("midreset busy/done/exc", {29'd0, busy, done, div_zero_exc}, 32'd0);
    saw_done = 0;
    repeat (40) begin tick(); if (done || busy) saw_done++; end
    check("post-reset idle", saw_done, 0);
    check("post-reset hi kept", hi_out, 32'd0);

    // Write and op in the same cycle, then a write while busy.
    div_hi = 32'h11; div_lo = 32'h22;
    mthi_we = 1'b1; wr_data = 32'h777; div_req = 1'b1;
    tick();
    mthi_we = 1'b0; div_req = 1'b0;
    check("same-cycle write applied", hi_out, 32'h777);
    tick();
    mthi_we = 1'b1; wr_data = 32'hBAD;
    tick();
    mthi_we = 1'b0;
    check("busy write ignored", hi_out, 32'h777);
    waited = 0;
    while (!done && waited < 60) begin tick(); waited++; end
    check("op overwrites write", hi_out, 32'h11);
    mthi_we = 1'b1; mtlo_we = 1'b1; wr_data = 32'h1234;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    check("mthi idle", hi_out, 32'h1234);
    check("mtlo idle", lo_out, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
